// File: rtl/xrv_mext_issue.sv
// xrv_mext_issue: issue/writeback sequencer for the RV32M multiply group.
// Latches operands on accept, sends a one-cycle issue pulse to xrv_mult,
// holds the operands stable, stalls execute until the result returns and
// then presents a single writeback beat. Flush during a multiply is
// absorbed by draining the outstanding result.
//
// Optional feature: define XRV_MEXT_TIMEOUT_EN to enable a watchdog that
// aborts a multiply after TIMEOUT_CYCLES cycles without a result.

module xrv_mext_issue #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        ex_valid,
    input  logic        ex_is_mul,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        ex_stall,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic [2:0]  mult_type,
    output logic        mult_valid,
    input  logic [31:0] mult_result,
    input  logic        mult_result_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] mult_a_q, mult_b_q, wb_data_q;
    logic [1:0]  mult_op_q;
    logic [4:0]  rd_q;

    logic accept;
    logic result_take;
    logic timeout_hit;
    logic unused_funct3_b2;

    // Only funct3[1:0] selects the operation; bit 2 is zero for this group.
    assign unused_funct3_b2 = ex_funct3[2];

    assign accept      = (state_q == S_IDLE) & ex_valid & ex_is_mul &
                         (ex_rd != 5'd0) & ~flush;
    assign result_take = (state_q == S_WAIT) & mult_result_valid & ~flush;

`ifdef XRV_MEXT_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       waiting;

    assign waiting = (state_q == S_WAIT) | (state_q == S_DRAIN);

    // Watchdog count: cleared in ISSUE, advances while a result is owed
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_ISSUE) begin
            tmo_cnt_d = 8'd0;
        end else if (waiting) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    // Watchdog count register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = waiting & ~mult_result_valid &
                         (tmo_cnt_d == 8'(TIMEOUT_CYCLES));
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of process order.
            state_q <= state_d;
        end
    end

    // Operand / destination / result registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            // NOTE: these are plain datapath flops feeding outputs, so they
            // are reset to 0; a real RAM array would be left unreset.
            mult_a_q  <= 32'd0;
            mult_b_q  <= 32'd0;
            mult_op_q <= 2'd0;
            rd_q      <= 5'd0;
            wb_data_q <= 32'd0;
        end else begin
            if (accept) begin
                mult_a_q  <= ex_rs1;
                mult_b_q  <= ex_rs2;
                mult_op_q <= ex_funct3[1:0];
                rd_q      <= ex_rd;
            end
            if (result_take) begin
                wb_data_q <= mult_result;
            end
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch
        // is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (timeout_hit) begin
                    state_d = S_IDLE;
                end else if (mult_result_valid) begin
                    // A result coinciding with flush is simply dropped.
                    state_d = flush ? S_IDLE : S_DONE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mult_result_valid || timeout_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: issue pulse, writeback beat and execute stall
    always_comb begin
        mult_valid = 1'b0;
        wb_valid   = 1'b0;
        ex_stall   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ex_stall = accept;
            end
            S_ISSUE: begin
                mult_valid = ~flush;
                ex_stall   = ex_valid & ex_is_mul;
            end
            S_WAIT, S_DRAIN: begin
                ex_stall = ex_valid & ex_is_mul & ~timeout_hit;
            end
            S_DONE: begin
                wb_valid = ~flush;
            end
            default: ;
        endcase
    end

    assign err_timeout = timeout_hit;
    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign mult_type   = {1'b0, mult_op_q};
    assign wb_rd       = rd_q;
    assign wb_data     = wb_data_q;

endmodule
